cdc_handshake_xfer: RTL and testbench
=====================================

# cdc_handshake_xfer

Parametrised multi-bit clock- and reset-domain crossing that moves a WIDTH-bit word from the clk_a/rst_a_n domain to the clk_b/rst_b_n domain. It uses a toggle-based four-phase-free req/ack handshake with SYNC_STAGES-deep synchronisers. It replaces plain single-bit flop chains wherever a multi-bit word, back-pressure, or independent resets of either domain must be handled. Each side has a post-reset INIT phase so that a reset in one domain never duplicates or corrupts a transfer.

## Interface
- WIDTH, 8, data word width (≥1)
- SYNC_STAGES, 2, synchroniser depth for req and ack (≥2)
- CNT_W, 16, width of destination transfer counter
- clk_a  in  1  source clock
- rst_a_n  in  1  reset rst_a_n, asynchronous, active-low; clock clk_a
- clk_b  in  1  destination clock
- rst_b_n  in  1  destination reset, asynchronous, active-low, clock clk_b
- src_valid  in  1  source word offered (clk_a)
- src_ready  out  1  block can accept a word (clk_a)
- src_data  in  WIDTH  source word
- src_busy  out  1  a transfer is in flight (clk_a)
- dst_valid  out  1  word available (clk_b)
- dst_ready  in  1  consumer takes word (clk_b)
- dst_data  out  WIDTH  delivered word, stable while dst_valid=1
- dst_cnt  out  CNT_W  completed-delivery count, wraps modulo 2^CNT_W

## Operation
- Source FSM (clk_a) has three states: S_INIT, S_IDLE, S_WAIT.
  - S_INIT: entered on reset. Wait SYNC_STAGES+1 cycles, then load req ← ack_sync_a and go to S_IDLE.
  - S_IDLE: src_ready=1. On src_valid&src_ready: hold_reg ← src_data, req toggles, go to S_WAIT.
  - S_WAIT: src_ready=0, src_busy=1. hold_reg is frozen. When ack_sync_a==req, go to S_IDLE.
- Destination FSM (clk_b) has three states: D_INIT, D_IDLE, D_VALID.
  - D_INIT: entered on reset. Wait SYNC_STAGES+1 cycles, then load ack ← req_sync_b and go to D_IDLE.
  - D_IDLE: when req_sync_b≠ack: dst_data ← hold_reg (the only multi-bit crossing; it is stable by protocol), dst_valid ← 1, go to D_VALID.
  - D_VALID: when dst_ready=1: dst_valid ← 0, ack toggles, dst_cnt increments, go to D_IDLE.
- req and ack are single flops, each synchronised through SYNC_STAGES flops in the receiving domain. No combinational logic is allowed before the synchroniser input.
- Reset of rst_b_n alone during a transfer:
  - D_INIT adopts req, so the in-flight word is dropped, never duplicated.
  - The source then sees ack==req and returns to S_IDLE.
- Reset of rst_a_n alone:
  - S_INIT adopts ack, so no spurious transfer is issued.
  - A word already in D_VALID is still delivered.
- Both resets asserted together return the block to its clean idle state.
- Reset values:
  - src_ready=0, src_busy=0, hold_reg=0, req=0.
  - dst_valid=0, dst_data=0, ack=0, dst_cnt=0.
  - All synchroniser flops reset to 0 in their own domain.

## Timing
- Source accept at clk_a edge A0: req toggles at A0, and src_ready=0 from A0 onward.
- dst_valid rises at the SYNC_STAGES+1-th clk_b edge after req is sampled by the first synchroniser flop.
- Transfer completes at clk_b edge B_r where dst_valid&dst_ready: ack toggles at B_r.
- src_ready returns high SYNC_STAGES+1 clk_a edges after ack is first sampled.
- Throughput is one word per round trip; no pipelining of words.
- src_valid is a don't-care while src_ready=0; src_data is sampled only on the accept edge.
- dst_valid holds until dst_ready; dst_data does not change while dst_valid=1.
- dst_valid&dst_ready on the same edge a new req arrives: the new word is not seen until the cycle after the return to D_IDLE, because that new req is impossible by protocol.
- dst_cnt wraps from 2^CNT_W−1 to 0.

## Test plan
- Equal clocks, both resets released, send 0xA5 then 0x3C with dst_ready=1 → dst_data=0xA5 then 0x3C, dst_cnt=2, no duplicates.
- clk_a 100 MHz, clk_b 37 MHz, 1000 random words, random dst_ready → output sequence equals input sequence, dst_cnt=1000.
- dst_ready=0 for 50 cycles with word 0x77 pending → dst_valid stays 1, dst_data=0x77, src_ready stays 0, src_busy=1.
- Pulse rst_b_n while the source is in S_WAIT with word 0x11 → 0x11 is not delivered, src_ready returns to 1 within SYNC_STAGES+1 clk_a cycles after D_INIT exits, and the next word 0x22 is delivered once.
- Pulse rst_a_n while dst_valid=1 with word 0x44 → 0x44 is delivered, src_ready=1 after S_INIT, and no extra dst_valid occurs.
- CNT_W=4, 17 transfers → dst_cnt reads 1 after the wrap.

Source files
------------

// File: rtl/cdc_handshake_xfer.sv
// Purpose : moves one WIDTH-bit word from the clk_a domain to the clk_b domain using a
//           toggle req/ack handshake, with independent asynchronous resets per domain.
// Latency : SYNC_STAGES+1 clk_b edges from req sampling to dst_valid; SYNC_STAGES+1 clk_a
//           edges from ack sampling back to src_ready. One word per round trip.
// Backpressure: dst_valid holds (dst_data frozen) until dst_ready; the source stays busy
//           (src_ready=0) until the acknowledgement has crossed back.
//
// Ports:
//   clk_a, rst_a_n        source clock and asynchronous active-low reset
//   clk_b, rst_b_n        destination clock and asynchronous active-low reset
//   src_valid/src_ready   source word handshake, src_data sampled on the accept edge
//   src_busy              a word is in flight (waiting for the acknowledgement)
//   dst_valid/dst_ready   destination word handshake, dst_data stable while dst_valid
//   dst_cnt               completed deliveries, wraps modulo 2^CNT_W

// Single-bit level synchroniser: STAGES flops, reset to 0 in the receiving domain.
// The input must come straight from a flop in the sending domain.
module cdc_handshake_xfer_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

module cdc_handshake_xfer #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic             clk_a,
    input  logic             rst_a_n,
    input  logic             clk_b,
    input  logic             rst_b_n,
    input  logic             src_valid,
    output logic             src_ready,
    input  logic [WIDTH-1:0] src_data,
    output logic             src_busy,
    output logic             dst_valid,
    input  logic             dst_ready,
    output logic [WIDTH-1:0] dst_data,
    output logic [CNT_W-1:0] dst_cnt
);

    // INIT lasts SYNC_STAGES+1 cycles: long enough for a freshly reset synchroniser
    // to refill with the true level of the other domain's flop before it is adopted.
    localparam int              INIT_W    = $clog2(SYNC_STAGES + 1);
    localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(SYNC_STAGES);

    typedef enum logic [1:0] {
        S_INIT = 2'd0,
        S_IDLE = 2'd1,
        S_WAIT = 2'd2
    } src_state_t;

    typedef enum logic [1:0] {
        D_INIT  = 2'd0,
        D_IDLE  = 2'd1,
        D_VALID = 2'd2
    } dst_state_t;

    // ------------------------------------------------------------------
    // Source domain (clk_a)
    // ------------------------------------------------------------------
    src_state_t        src_state;
    src_state_t        src_state_nxt;
    logic [INIT_W-1:0] src_init_cnt;
    logic [INIT_W-1:0] src_init_cnt_nxt;
    logic              req;
    logic              req_nxt;
    logic [WIDTH-1:0]  hold_reg;
    logic [WIDTH-1:0]  hold_reg_nxt;
    logic              ack_sync_a;

    // Destination-domain flops referenced across the boundary.
    logic              ack;

    cdc_handshake_xfer_sync #(
        .STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .clk   (clk_a),
        .rst_n (rst_a_n),
        .d     (ack),
        .q     (ack_sync_a)
    );

    always_ff @(posedge clk_a or negedge rst_a_n) begin
        if (!rst_a_n) begin
            src_state    <= S_INIT;
            src_init_cnt <= '0;
            req          <= 1'b0;
            hold_reg     <= '0;
        end else begin
            src_state    <= src_state_nxt;
            src_init_cnt <= src_init_cnt_nxt;
            req          <= req_nxt;
            hold_reg     <= hold_reg_nxt;
        end
    end

    always_comb begin
        src_state_nxt    = src_state;
        src_init_cnt_nxt = src_init_cnt;
        req_nxt          = req;
        hold_reg_nxt     = hold_reg;
        src_ready        = 1'b0;
        src_busy         = 1'b0;

        case (src_state)
            S_INIT: begin
                // Adopt the destination's ack level so a source-only reset never
                // looks like a new request.
                if (src_init_cnt == INIT_LAST) begin
                    req_nxt       = ack_sync_a;
                    src_state_nxt = S_IDLE;
                end else begin
                    src_init_cnt_nxt = src_init_cnt + 1'b1;
                end
            end
            S_IDLE: begin
                src_ready = 1'b1;
                if (src_valid) begin
                    hold_reg_nxt  = src_data;
                    req_nxt       = ~req;
                    src_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                // hold_reg stays frozen here; the destination reads it directly.
                src_busy = 1'b1;
                if (ack_sync_a == req) begin
                    src_state_nxt = S_IDLE;
                end
            end
            default: begin
                src_state_nxt = S_INIT;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Destination domain (clk_b)
    // ------------------------------------------------------------------
    dst_state_t        dst_state;
    dst_state_t        dst_state_nxt;
    logic [INIT_W-1:0] dst_init_cnt;
    logic [INIT_W-1:0] dst_init_cnt_nxt;
    logic              ack_nxt;
    logic              req_sync_b;
    logic              dst_valid_nxt;
    logic [WIDTH-1:0]  dst_data_nxt;
    logic [CNT_W-1:0]  dst_cnt_nxt;

    cdc_handshake_xfer_sync #(
        .STAGES (SYNC_STAGES)
    ) u_req_sync (
        .clk   (clk_b),
        .rst_n (rst_b_n),
        .d     (req),
        .q     (req_sync_b)
    );

    always_ff @(posedge clk_b or negedge rst_b_n) begin
        if (!rst_b_n) begin
            dst_state    <= D_INIT;
            dst_init_cnt <= '0;
            ack          <= 1'b0;
            dst_valid    <= 1'b0;
            dst_data     <= '0;
            dst_cnt      <= '0;
        end else begin
            dst_state    <= dst_state_nxt;
            dst_init_cnt <= dst_init_cnt_nxt;
            ack          <= ack_nxt;
            dst_valid    <= dst_valid_nxt;
            dst_data     <= dst_data_nxt;
            dst_cnt      <= dst_cnt_nxt;
        end
    end

    always_comb begin
        dst_state_nxt    = dst_state;
        dst_init_cnt_nxt = dst_init_cnt;
        ack_nxt          = ack;
        dst_valid_nxt    = dst_valid;
        dst_data_nxt     = dst_data;
        dst_cnt_nxt      = dst_cnt;

        case (dst_state)
            D_INIT: begin
                // Adopt the current req level: a word in flight at reset is dropped
                // (acknowledged without delivery) rather than delivered twice.
                if (dst_init_cnt == INIT_LAST) begin
                    ack_nxt       = req_sync_b;
                    dst_state_nxt = D_IDLE;
                end else begin
                    dst_init_cnt_nxt = dst_init_cnt + 1'b1;
                end
            end
            D_IDLE: begin
                // hold_reg has been stable since before req toggled, so sampling it
                // once the synchronised req differs from ack is safe.
                if (req_sync_b != ack) begin
                    dst_data_nxt  = hold_reg;
                    dst_valid_nxt = 1'b1;
                    dst_state_nxt = D_VALID;
                end
            end
            D_VALID: begin
                if (dst_ready) begin
                    dst_valid_nxt = 1'b0;
                    // In normal operation req_sync_b == ~ack here, so this is the ack
                    // toggle. If the source was reset while this word was pending,
                    // req has fallen back to ack and matching it avoids a phantom
                    // request being seen in D_IDLE.
                    ack_nxt       = req_sync_b;
                    dst_cnt_nxt   = dst_cnt + 1'b1;
                    dst_state_nxt = D_IDLE;
                end
            end
            default: begin
                dst_state_nxt = D_INIT;
            end
        endcase
    end

endmodule

// File: tb/tb_cdc_handshake_xfer.sv
module tb_cdc_handshake_xfer;

    localparam int W  = 8;
    localparam int SS = 2;

    logic clk_a   = 1'b0;
    logic clk_b   = 1'b0;
    logic rst_a_n = 1'b0;
    logic rst_b_n = 1'b0;
    int   hb_b    = 50;

    always #50 clk_a = ~clk_a;
    always #(hb_b) clk_b = ~clk_b;

    logic         src_valid = 1'b0;
    logic         src_ready;
    logic [W-1:0] src_data = '0;
    logic         src_busy;
    logic         dst_valid;
    logic         dst_ready = 1'b0;
    logic [W-1:0] dst_data;
    logic [15:0]  dst_cnt;

    logic         src_valid4 = 1'b0;
    logic         src_ready4;
    logic [W-1:0] src_data4 = '0;
    logic         src_busy4;
    logic         dst_valid4;
    logic         dst_ready4 = 1'b0;
    logic [W-1:0] dst_data4;
    logic [3:0]   dst_cnt4;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    cdc_handshake_xfer #(.WIDTH(W), .SYNC_STAGES(SS), .CNT_W(16)) u_dut (
        .clk_a(clk_a), .rst_a_n(rst_a_n), .clk_b(clk_b), .rst_b_n(rst_b_n),
        .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data), .src_busy(src_busy),
        .dst_valid(dst_valid), .dst_ready(dst_ready), .dst_data(dst_data), .dst_cnt(dst_cnt)
    );

    cdc_handshake_xfer #(.WIDTH(W), .SYNC_STAGES(SS), .CNT_W(4)) u_dut4 (
        .clk_a(clk_a), .rst_a_n(rst_a_n), .clk_b(clk_b), .rst_b_n(rst_b_n),
        .src_valid(src_valid4), .src_ready(src_ready4), .src_data(src_data4), .src_busy(src_busy4),
        .dst_valid(dst_valid4), .dst_ready(dst_ready4), .dst_data(dst_data4), .dst_cnt(dst_cnt4)
    );

    initial begin
        #40_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers (drive only) ----------------
    task automatic reset_both();
        src_valid  = 1'b0;
        dst_ready  = 1'b0;
        src_valid4 = 1'b0;
        dst_ready4 = 1'b0;
        @(negedge clk_a);
        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        repeat (3) @(negedge clk_b);
        @(negedge clk_a);
        rst_a_n = 1'b1;
        @(negedge clk_b);
        rst_b_n = 1'b1;
        repeat (20) @(negedge clk_b);
    endtask

    // Offer a word; src_valid/src_data are randomised while src_ready=0.
    task automatic src_send(input logic [W-1:0] w, input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk_a);
            if (src_ready) begin
                src_valid = 1'b1;
                src_data  = w;
                ok        = 1'b1;
                break;
            end else begin
                src_valid = 1'($urandom_range(1));
                src_data  = W'($urandom);
            end
        end
        if (ok) @(negedge clk_a);
        src_valid = 1'b0;
        src_data  = W'($urandom);
    endtask

    // Consume one word with dst_ready asserted pct% of cycles.
    task automatic take_word(input int pct, input int max_cyc, output bit got, output logic [W-1:0] d);
        got = 1'b0;
        d   = '0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk_b);
            dst_ready = ($urandom_range(99) < pct);
            if (dst_valid && dst_ready) begin
                got = 1'b1;
                d   = dst_data;
                break;
            end
        end
        if (got) @(negedge clk_b);
        dst_ready = 1'b0;
    endtask

    task automatic count_valid(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk_b);
            if (dst_valid) cnt++;
        end
    endtask

    task automatic wait_dst_valid(input int max_cyc, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk_b);
            if (dst_valid) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        repeat (3) @(negedge clk_a);
        checks++; if (src_ready !== 1'b0) begin errors++; $display("FAIL reset_src_ready: got %b expected 0", src_ready); end
        checks++; if (src_busy !== 1'b0) begin errors++; $display("FAIL reset_src_busy: got %b expected 0", src_busy); end
        checks++; if (dst_valid !== 1'b0) begin errors++; $display("FAIL reset_dst_valid: got %b expected 0", dst_valid); end
        checks++; if (dst_data !== 8'h00) begin errors++; $display("FAIL reset_dst_data: got %h expected 00", dst_data); end
        checks++; if (dst_cnt !== 16'd0) begin errors++; $display("FAIL reset_dst_cnt: got %0d expected 0", dst_cnt); end
        checks++; if (dst_cnt4 !== 4'd0 || src_busy4 !== 1'b0) begin errors++; $display("FAIL reset_dut4: cnt %0d busy %b expected 0 0", dst_cnt4, src_busy4); end
        rst_a_n = 1'b1;
        rst_b_n = 1'b1;
        // Source INIT spans SYNC_STAGES+1 edges before src_ready rises.
        for (int k = 1; k <= SS + 1; k++) begin
            @(negedge clk_a);
            checks++;
            if (src_ready !== (k == SS + 1)) begin
                errors++;
                $display("FAIL init_src_ready[%0d]: got %b expected %b", k, src_ready, (k == SS + 1));
            end
        end
        repeat (10) @(negedge clk_b);
        checks++; if (dst_valid !== 1'b0) begin errors++; $display("FAIL init_dst_valid: got %b expected 0", dst_valid); end
    endtask

    task automatic test_basic();
        logic [W-1:0] words[2];
        logic [W-1:0] d;
        bit ok, got;
        int extra;
        words[0] = 8'hA5;
        words[1] = 8'h3C;
        reset_both();
        for (int i = 0; i < 2; i++) begin
            src_send(words[i], 100, ok);
            checks++; if (!ok) begin errors++; $display("FAIL basic_accept[%0d]: src_ready never seen", i); end
            checks++; if (src_ready !== 1'b0 || src_busy !== 1'b1) begin errors++; $display("FAIL basic_busy[%0d]: ready %b busy %b expected 0 1", i, src_ready, src_busy); end
            take_word(100, 100, got, d);
            checks++; if (!got || d !== words[i]) begin errors++; $display("FAIL basic_data[%0d]: got %h (valid %b) expected %h", i, d, got, words[i]); end
        end
        count_valid(20, extra);
        checks++; if (extra !== 0) begin errors++; $display("FAIL basic_dup: got %0d extra valid cycles expected 0", extra); end
        checks++; if (dst_cnt !== 16'd2) begin errors++; $display("FAIL basic_cnt: got %0d expected 2", dst_cnt); end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] d;
        bit ok, got, seen;
        int bad;
        reset_both();
        src_send(8'h77, 100, ok);
        wait_dst_valid(50, seen);
        checks++; if (!ok || !seen) begin errors++; $display("FAIL bp_arrive: accept %b valid %b expected 1 1", ok, seen); end
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_b);
            checks++;
            if (dst_valid !== 1'b1 || dst_data !== 8'h77 || src_ready !== 1'b0 || src_busy !== 1'b1) begin
                errors++;
                if (bad < 3) $display("FAIL bp_hold[%0d]: valid %b data %h ready %b busy %b expected 1 77 0 1",
                                      i, dst_valid, dst_data, src_ready, src_busy);
                bad++;
            end
        end
        take_word(100, 10, got, d);
        checks++; if (!got || d !== 8'h77) begin errors++; $display("FAIL bp_data: got %h (valid %b) expected 77", d, got); end
        checks++; if (dst_cnt !== 16'd1) begin errors++; $display("FAIL bp_cnt: got %0d expected 1", dst_cnt); end
    endtask

    task automatic test_dst_reset();
        logic [W-1:0] d;
        bit ok, got, seen;
        int extra;
        reset_both();
        src_send(8'h11, 100, ok);
        wait_dst_valid(50, seen);
        checks++; if (!ok || !seen) begin errors++; $display("FAIL dreset_arrive: accept %b valid %b expected 1 1", ok, seen); end
        @(negedge clk_b);
        rst_b_n = 1'b0;
        repeat (2) @(negedge clk_b);
        checks++; if (dst_valid !== 1'b0 || dst_cnt !== 16'd0) begin errors++; $display("FAIL dreset_dst: valid %b cnt %0d expected 0 0", dst_valid, dst_cnt); end
        checks++; if (src_busy !== 1'b1) begin errors++; $display("FAIL dreset_src_busy: got %b expected 1", src_busy); end
        rst_b_n = 1'b1;
        dst_ready = 1'b1;
        repeat (SS + 1) @(posedge clk_b);
        // One extra edge of slack for the ack change landing on a clk_a edge.
        seen = 1'b0;
        for (int k = 0; k < SS + 2; k++) begin
            @(negedge clk_a);
            if (src_ready) begin
                seen = 1'b1;
                break;
            end
        end
        checks++; if (!seen) begin errors++; $display("FAIL dreset_src_ready: got 0 expected 1 within %0d clk_a cycles", SS + 2); end
        count_valid(20, extra);
        checks++; if (extra !== 0) begin errors++; $display("FAIL dreset_dropped: got %0d valid cycles for 0x11 expected 0", extra); end
        dst_ready = 1'b0;
        src_send(8'h22, 100, ok);
        take_word(100, 100, got, d);
        checks++; if (!ok || !got || d !== 8'h22) begin errors++; $display("FAIL dreset_next: got %h (accept %b valid %b) expected 22", d, ok, got); end
        dst_ready = 1'b1;
        count_valid(20, extra);
        dst_ready = 1'b0;
        checks++; if (extra !== 0) begin errors++; $display("FAIL dreset_dup: got %0d extra valid cycles expected 0", extra); end
        checks++; if (dst_cnt !== 16'd1) begin errors++; $display("FAIL dreset_cnt: got %0d expected 1", dst_cnt); end
    endtask

    task automatic test_src_reset();
        logic [W-1:0] d;
        bit ok, got, seen;
        int extra;
        reset_both();
        src_send(8'h44, 100, ok);
        wait_dst_valid(50, seen);
        checks++; if (!ok || !seen) begin errors++; $display("FAIL sreset_arrive: accept %b valid %b expected 1 1", ok, seen); end
        @(negedge clk_a);
        rst_a_n = 1'b0;
        repeat (2) @(negedge clk_a);
        checks++; if (src_ready !== 1'b0 || src_busy !== 1'b0) begin errors++; $display("FAIL sreset_in_reset: ready %b busy %b expected 0 0", src_ready, src_busy); end
        rst_a_n = 1'b1;
        for (int k = 1; k <= SS + 1; k++) begin
            @(negedge clk_a);
            checks++;
            if (src_ready !== (k == SS + 1)) begin
                errors++;
                $display("FAIL sreset_init[%0d]: src_ready %b expected %b", k, src_ready, (k == SS + 1));
            end
        end
        checks++; if (dst_valid !== 1'b1 || dst_data !== 8'h44) begin errors++; $display("FAIL sreset_pending: valid %b data %h expected 1 44", dst_valid, dst_data); end
        take_word(100, 10, got, d);
        checks++; if (!got || d !== 8'h44) begin errors++; $display("FAIL sreset_data: got %h (valid %b) expected 44", d, got); end
        dst_ready = 1'b1;
        count_valid(30, extra);
        dst_ready = 1'b0;
        checks++; if (extra !== 0) begin errors++; $display("FAIL sreset_extra: got %0d extra valid cycles expected 0", extra); end
        checks++; if (dst_cnt !== 16'd1 || src_ready !== 1'b1) begin errors++; $display("FAIL sreset_end: cnt %0d ready %b expected 1 1", dst_cnt, src_ready); end
    endtask

    task automatic test_random();
        localparam int N = 1000;
        bit abort;
        hb_b = 135;
        reset_both();
        exp_q.delete();
        abort = 1'b0;
        fork
            begin
                logic [W-1:0] w;
                bit ok;
                for (int i = 0; i < N && !abort; i++) begin
                    repeat ($urandom_range(3)) @(negedge clk_a);
                    w = W'($urandom);
                    src_send(w, 2000, ok);
                    if (!ok) begin
                        checks++; errors++;
                        $display("FAIL rand_accept[%0d]: src_ready never seen", i);
                        abort = 1'b1;
                    end else begin
                        exp_q.push_back(w);
                    end
                end
            end
            begin
                logic [W-1:0] d;
                logic [W-1:0] e;
                bit got;
                for (int i = 0; i < N && !abort; i++) begin
                    take_word(50, 2000, got, d);
                    checks++;
                    if (!got) begin
                        errors++;
                        $display("FAIL rand_timeout[%0d]: no dst_valid", i);
                        abort = 1'b1;
                    end else if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL rand_unexpected[%0d]: got %h expected nothing", i, d);
                    end else begin
                        e = exp_q.pop_front();
                        if (d !== e) begin
                            errors++;
                            $display("FAIL rand_data[%0d]: got %h expected %h", i, d, e);
                        end
                    end
                end
            end
        join
        repeat (10) @(negedge clk_b);
        checks++; if (dst_cnt !== 16'(N)) begin errors++; $display("FAIL rand_cnt: got %0d expected %0d", dst_cnt, N); end
        checks++; if (exp_q.size() != 0 || dst_valid !== 1'b0) begin errors++; $display("FAIL rand_leftover: queue %0d valid %b expected 0 0", exp_q.size(), dst_valid); end
        hb_b = 50;
    endtask

    task automatic test_wrap();
        logic [W-1:0] w;
        logic [W-1:0] d;
        bit ok, got;
        int exp_cnt;
        reset_both();
        dst_ready4 = 1'b1;
        for (int i = 0; i < 17; i++) begin
            w  = W'($urandom);
            ok = 1'b0;
            for (int j = 0; j < 100; j++) begin
                @(negedge clk_a);
                if (src_ready4) begin
                    src_valid4 = 1'b1;
                    src_data4  = w;
                    ok         = 1'b1;
                    break;
                end
            end
            if (ok) @(negedge clk_a);
            src_valid4 = 1'b0;
            got = 1'b0;
            d   = '0;
            for (int j = 0; j < 100; j++) begin
                @(negedge clk_b);
                if (dst_valid4) begin
                    got = 1'b1;
                    d   = dst_data4;
                    break;
                end
            end
            if (got) @(negedge clk_b);
            exp_cnt = (i + 1) % 16;
            checks++;
            if (!ok || !got || d !== w || dst_cnt4 !== 4'(exp_cnt)) begin
                errors++;
                $display("FAIL wrap[%0d]: data %h cnt %0d (accept %b valid %b) expected %h %0d",
                         i, d, dst_cnt4, ok, got, w, exp_cnt);
            end
        end
        dst_ready4 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_dst_reset();
        test_src_reset();
        test_random();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
